parity_mem_ctrl: RTL
====================

PARITY_MEM_CTRL -- requirements
Module: parity_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-003 Parameter ODD_PARITY, default 0, 0 = even parity, 1 = odd parity.
REQ-004 Parameter CNT_W, default 16, error-counter width.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 write  input  1  write request for the current cycle.
REQ-008 read  input  1  read request for the current cycle.
REQ-009 address  input  ADDR_W  word address for read or write.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 inj_err  input  1  when high with a write, stores the inverted parity bit (test hook).
REQ-012 clr_count  input  1  synchronous clear of err_count.
REQ-013 data_out  output  DATA_W+1  registered read word, {parity, data}.
REQ-014 rd_valid  output  1  one-cycle pulse: data_out holds the result of a read.
REQ-015 parity_err  output  1  one-cycle pulse with rd_valid: the stored parity does not match the recomputed parity.
REQ-016 uninit_rd  output  1  one-cycle pulse with rd_valid: the addressed word was never written since reset.
REQ-017 collision  output  1  one-cycle pulse, the cycle after write and read were both high.
REQ-018 err_count  output  CNT_W  saturating count of error events.

Function
REQ-019 A write-only cycle SHALL store {P(data_in)^inj_err, data_in} at address and set that word's valid bit; P is the parity selected by ODD_PARITY.
REQ-020 A read-only cycle SHALL update data_out, rd_valid, parity_err and uninit_rd at the next posedge (latency 1).
REQ-021 A read of an unwritten word SHALL return data_out=0 with uninit_rd=1 and parity_err=0.
REQ-022 A cycle with both write and read high SHALL perform neither operation, pulse collision next cycle, and hold rd_valid=0.
REQ-023 data_out SHALL hold its last value when rd_valid=0.
REQ-024 A write followed by a read of the same address in the next cycle SHALL return the newly written word.
REQ-025 Per cycle, err_count SHALL increment by the sum of collision and parity_err as they assert, and saturate at 2**CNT_W-1 with no wrap.
REQ-026 clr_count SHALL take priority: err_count becomes 0 that cycle and ignores any coincident increments.
REQ-027 uninit_rd SHALL NOT increment err_count.

Reset
REQ-028 On rst, data_out, rd_valid, parity_err, uninit_rd, collision and err_count SHALL go to 0 immediately, and all valid bits SHALL clear.
REQ-029 Memory data contents SHALL NOT be reset.
REQ-030 A read issued in the cycle rst deasserts SHALL complete normally.
REQ-031 A read in flight when rst asserts SHALL produce no rd_valid.

Structure
REQ-032 Package parity_mem_pkg SHALL hold the default parameter constants and the parity function calc_parity(data, odd).
REQ-033 Sub-module parity_calc (combinational, DATA_W-generic) SHALL be instantiated twice: once for write-side generation and once for read-side check.
REQ-034 Storage SHALL be an unreset array of (DATA_W+1)-bit words plus a 2**ADDR_W-bit valid vector with asynchronous reset.

Verification
REQ-035 Write 0xA5 to addr 0x10, then read 0x10 (even parity) -> next cycle data_out=0x0A5, rd_valid=1, parity_err=0.
REQ-036 Write 0x07 with inj_err=1 to addr 0x20, then read 0x20 -> data_out=0x007, parity_err=1, err_count=1.
REQ-037 write=read=1 for 3 consecutive cycles -> collision high 3 cycles, memory unchanged, err_count=3, rd_valid=0.
REQ-038 After reset, read addr 0x33 -> data_out=0, uninit_rd=1, err_count=0.
REQ-039 With CNT_W=4, force 20 collisions -> err_count stops at 15; then clr_count with a coincident collision -> err_count=0.
REQ-040 Assert rst in the cycle after a read request -> rd_valid never pulses, all outputs 0; the next read of a previously written address reports uninit_rd=1.

Source files
------------

// File: rtl/parity_mem_pkg.sv
// Shared constants and the parity helper for the parity-protected memory controller.
package parity_mem_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_ODD_PARITY = 0;
  localparam int DEF_CNT_W      = 16;
  localparam int MAX_DATA_W     = 64;

  // Zero-extension does not change XOR parity, so narrower words are widened by the caller.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_mem_if.sv
// Request/response bundle between a requester and parity_mem_ctrl.
// Requests are single-cycle strobes with no back-pressure: write and read are acted on in the
// cycle they are high (both high is a collision); rd_valid pulses one cycle later with the result.
interface parity_mem_if
  import parity_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              inj_err;
  logic              clr_count;
  logic [DATA_W:0]   data_out;
  logic              rd_valid;
  logic              parity_err;
  logic              uninit_rd;
  logic              collision;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output write, read, address, data_in, inj_err, clr_count,
    input  data_out, rd_valid, parity_err, uninit_rd, collision, err_count
  );

  modport slave (
    input  write, read, address, data_in, inj_err, clr_count,
    output data_out, rd_valid, parity_err, uninit_rd, collision, err_count
  );

endinterface

// File: rtl/parity_calc.sv
// Combinational parity generator for a DATA_W-bit word (even or odd selected by ODD).
module parity_calc
  import parity_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter bit ODD    = 1'b0
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  logic [MAX_DATA_W-1:0] data_ext;

  assign data_ext = MAX_DATA_W'(data);
  assign parity   = calc_parity(data_ext, ODD);

endmodule

// File: rtl/parity_mem_ctrl.sv
// Single-port memory with per-word parity, written-since-reset tracking, collision detection
// and a saturating error counter.
module parity_mem_ctrl
  import parity_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ODD_PARITY = DEF_ODD_PARITY,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic         clk,
  input logic         rst,
  parity_mem_if.slave bus
);

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W:0]  mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             wr_en;
  logic             rd_en;
  logic             wr_parity;
  logic [DATA_W:0]  rd_word;
  logic             rd_parity;
  logic             rd_hit;
  logic             perr_nxt;
  logic             coll_nxt;
  logic [1:0]       inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_nxt;

  logic [DATA_W:0]  data_out_q;
  logic             rd_valid_q;
  logic             parity_err_q;
  logic             uninit_rd_q;
  logic             collision_q;
  logic [CNT_W-1:0] err_count_q;

  assign wr_en = bus.write & ~bus.read;
  assign rd_en = bus.read & ~bus.write;

  parity_calc #(.DATA_W(DATA_W), .ODD(ODD_PARITY != 0)) u_wr_parity (
    .data   (bus.data_in),
    .parity (wr_parity)
  );

  assign rd_word = mem[bus.address];
  assign rd_hit  = valid[bus.address];

  parity_calc #(.DATA_W(DATA_W), .ODD(ODD_PARITY != 0)) u_rd_parity (
    .data   (rd_word[DATA_W-1:0]),
    .parity (rd_parity)
  );

  // Data array is deliberately unreset; the valid vector alone decides whether a word is usable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.address] <= {wr_parity ^ bus.inj_err, bus.data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[bus.address] <= 1'b1;
    end
  end

  assign perr_nxt = rd_en & rd_hit & (rd_word[DATA_W] != rd_parity);
  assign coll_nxt = bus.write & bus.read;

  // The counter advances on the same edge that raises the pulses it counts.
  assign inc     = 2'(coll_nxt) + 2'(perr_nxt);
  assign sum     = {1'b0, err_count_q} + (CNT_W + 1)'(inc);
  assign cnt_nxt = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      uninit_rd_q  <= 1'b0;
      collision_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      rd_valid_q   <= rd_en;
      parity_err_q <= perr_nxt;
      uninit_rd_q  <= rd_en & ~rd_hit;
      collision_q  <= coll_nxt;
      if (rd_en) begin
        data_out_q <= rd_hit ? rd_word : '0;
      end
      err_count_q  <= bus.clr_count ? '0 : cnt_nxt;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.uninit_rd  = uninit_rd_q;
  assign bus.collision  = collision_q;
  assign bus.err_count  = err_count_q;

endmodule
